// File: rtl/mdac_pkg.sv
// Shared types and constants for the mdac multiply/accumulate datapath.
package mdac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_ACC_GUARD = 4;

  // Iteration counter width able to hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdac_reg.sv
// Width-parameterised register with load enable and async active-low clear,
// built one flip-flop per bit.
module mdac_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    logic bit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        bit_q <= 1'b0;
      end else if (en_i) begin
        bit_q <= d_i[i];
      end
    end

    assign q_o[i] = bit_q;
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one partial-product bit per clock,
// with an optional accumulate of each completed product.
module shift_add_mult
  import mdac_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_GUARD = DEFAULT_ACC_GUARD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           acc_en,
  input  logic                           acc_clr,
  output logic                           ready,
  output logic                           done,
  output logic [2*WIDTH-1:0]             product,
  output logic [2*WIDTH+ACC_GUARD-1:0]   acc,
  output logic                           acc_ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + ACC_GUARD;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic            ready_q, done_q, acc_en_q, acc_ovf_q;

  logic [PW-1:0]    mcand_q, mcand_d, psum_q, psum_d, product_q;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW:0]      acc_sum;
  logic             load, step, finish, acc_add, acc_wr;

  always_comb begin
    load    = (state_q == IDLE) && start;
    step    = (state_q == RUN);
    finish  = step && (count_q == LastCnt);
    acc_add = finish && acc_en_q;
    acc_wr  = acc_add || acc_clr;

    mcand_d  = load ? PW'(a) : (mcand_q << 1);
    mplier_d = load ? b : (mplier_q >> 1);
    psum_d   = load ? '0 : (mplier_q[0] ? psum_q + mcand_q : psum_q);

    // Clear wins over the old value but still lets the new product land.
    acc_sum = (acc_clr ? '0 : {1'b0, acc_q}) + (AW + 1)'(psum_d);
    acc_d   = acc_add ? acc_sum[AW-1:0] : '0;
  end

  mdac_reg #(.Width(PW)) u_mcand (
    .clk_i(clk), .rst_ni(reset_n), .en_i(load || step), .d_i(mcand_d), .q_o(mcand_q)
  );

  mdac_reg #(.Width(WIDTH)) u_mplier (
    .clk_i(clk), .rst_ni(reset_n), .en_i(load || step), .d_i(mplier_d), .q_o(mplier_q)
  );

  mdac_reg #(.Width(PW)) u_psum (
    .clk_i(clk), .rst_ni(reset_n), .en_i(load || step), .d_i(psum_d), .q_o(psum_q)
  );

  mdac_reg #(.Width(PW)) u_product (
    .clk_i(clk), .rst_ni(reset_n), .en_i(finish), .d_i(psum_d), .q_o(product_q)
  );

  mdac_reg #(.Width(AW)) u_acc (
    .clk_i(clk), .rst_ni(reset_n), .en_i(acc_wr), .d_i(acc_d), .q_o(acc_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      acc_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            count_q  <= '0;
            ready_q  <= 1'b0;
            acc_en_q <= acc_en;
          end
        end
        RUN: begin
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_ovf_q <= 1'b0;
    end else if (acc_clr) begin
      acc_ovf_q <= 1'b0;
    end else if (acc_add && acc_sum[AW]) begin
      acc_ovf_q <= 1'b1;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;
  assign acc     = acc_q;
  assign acc_ovf = acc_ovf_q;

endmodule
